// File: rtl/alu_8bit_pkg.sv
// ============================================================================
// Module   : alu_8bit_pkg
// Brief    : Shared width and opcode encodings for the 8-bit ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_8bit_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0111;
  localparam logic [3:0] OP_XNOR = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam logic [3:0] OP_MUL  = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [3:0] OP_ASR  = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/alu_8bit_divider.sv
// ============================================================================
// Module   : alu_8bit_divider
// Brief    : Combinational unsigned restoring divider (quotient only).
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_8bit_divider
  import alu_8bit_pkg::*;
(
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quotient,
  output logic              o_div_by_zero
);

  logic [DATA_W:0]   w_rem;
  logic [DATA_W-1:0] w_quot;

  // One shift-compare-subtract step per quotient bit, MSB first.
  always_comb begin
    w_rem  = '0;
    w_quot = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_rem = {w_rem[DATA_W-1:0], i_dividend[i]};
      if (w_rem >= {1'b0, i_divisor}) begin
        w_rem     = w_rem - {1'b0, i_divisor};
        w_quot[i] = 1'b1;
      end
    end
  end

  assign o_quotient    = w_quot;
  assign o_div_by_zero = (i_divisor == '0);

endmodule

`default_nettype wire

// File: rtl/alu_8bit.sv
// ============================================================================
// Module   : alu_8bit
// Brief    : 8-bit registered ALU, 16 opcodes, carry/zero/overflow/sign flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_8bit
  import alu_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              overflow,
  output logic              sign
);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic                w_div0;
  logic [DATA_W-1:0]   w_res;
  logic                w_carry;
  logic                w_ovf;

  logic [DATA_W-1:0]   r_result;
  logic                r_carry;
  logic                r_zero;
  logic                r_ovf;
  logic                r_sign;

  // Borrow of the subtraction lands in bit 8 when A < B.
  assign w_sum  = {1'b0, A} + {1'b0, B};
  assign w_diff = {1'b0, A} - {1'b0, B};
  assign w_prod = {{DATA_W{1'b0}}, A} * {{DATA_W{1'b0}}, B};

  alu_8bit_divider u_divider (
    .i_dividend    (A),
    .i_divisor     (B),
    .o_quotient    (w_quot),
    .o_div_by_zero (w_div0)
  );

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (opcode)
      OP_ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
        w_ovf   = (A[7] == B[7]) && (w_sum[7] != A[7]);
      end
      OP_SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
        w_ovf   = (A[7] != B[7]) && (w_diff[7] != A[7]);
      end
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOT:  w_res = ~A;
      OP_NAND: w_res = ~(A & B);
      OP_NOR:  w_res = ~(A | B);
      OP_XNOR: w_res = ~(A ^ B);
      OP_SHL: begin
        w_res   = {A[6:0], 1'b0};
        w_carry = A[7];
      end
      OP_SHR: begin
        w_res   = {1'b0, A[7:1]};
        w_carry = A[0];
      end
      OP_ROL: begin
        w_res   = {A[6:0], A[7]};
        w_carry = A[7];
      end
      OP_ROR: begin
        w_res   = {A[0], A[7:1]};
        w_carry = A[0];
      end
      OP_MUL: begin
        w_res   = w_prod[DATA_W-1:0];
        w_carry = (w_prod[2*DATA_W-1:DATA_W] != '0);
        w_ovf   = w_carry;
      end
      OP_DIV: begin
        w_res   = w_div0 ? {DATA_W{1'b1}} : w_quot;
        w_carry = w_div0;
      end
      OP_ASR: begin
        w_res   = {A[7], A[7:1]};
        w_carry = A[0];
      end
      default: begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sign   <= 1'b0;
    end else begin
      r_result <= w_res;
      r_carry  <= w_carry;
      r_zero   <= (w_res == '0);
      r_ovf    <= w_ovf;
      r_sign   <= w_res[7];
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign sign     = r_sign;

endmodule

`default_nettype wire

// File: tb/tb_alu_8bit.sv
// ============================================================================
// Module   : tb_alu_8bit
// Brief    : Self-checking bench for alu_8bit: vector table, random vs model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] opcode;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       overflow;
  logic       sign;

  int checks;
  int errors;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       s;
  } vec_t;

  alu_8bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow),
    .sign     (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model from plain integer arithmetic; packs {res,c,z,v,s}.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    int ua, ub, sa, sb, t, r, c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 0;
    v = 0;
    r = 0;
    case (op)
      4'd0: begin
        t = ua + ub; r = t % 256; c = (t > 255) ? 1 : 0;
        v = (sa + sb > 127 || sa + sb < -128) ? 1 : 0;
      end
      4'd1: begin
        r = (ua - ub + 256) % 256; c = (ua < ub) ? 1 : 0;
        v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
      end
      4'd2:  r = int'(a & b);
      4'd3:  r = int'(a | b);
      4'd4:  r = int'(a ^ b);
      4'd5:  r = 255 - ua;
      4'd6:  r = 255 - int'(a & b);
      4'd7:  r = 255 - int'(a | b);
      4'd8:  r = 255 - int'(a ^ b);
      4'd9:  begin r = (ua * 2) % 256; c = ua / 128; end
      4'd10: begin r = ua / 2; c = ua % 2; end
      4'd11: begin r = (ua * 2) % 256 + ua / 128; c = ua / 128; end
      4'd12: begin r = ua / 2 + (ua % 2) * 128; c = ua % 2; end
      4'd13: begin
        t = ua * ub; r = t % 256; c = (t > 255) ? 1 : 0; v = c;
      end
      4'd14: begin
        if (ub == 0) begin r = 255; c = 1; end
        else r = ua / ub;
      end
      default: begin r = ua / 2 + ((ua >= 128) ? 128 : 0); c = ua % 2; end
    endcase
    model = {r[7:0], c[0], (r == 0), v[0], (r >= 128)};
  endfunction

  task automatic chk(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {result, carry, zero, overflow, sign};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got res=%h CZVS=%b required res=%h CZVS=%b",
               name, got[11:4], got[3:0], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    A = a;
    B = b;
    opcode = op;
  endtask

  vec_t tbl[16];

  initial begin
    logic [11:0] prev;
    logic [11:0] exp;
    logic [7:0]  ra, rb;
    logic [3:0]  rop;

    checks = 0;
    errors = 0;

    tbl[0]  = '{8'h0F, 8'h01, 4'd0,  8'h10, 0, 0, 0, 0};
    tbl[1]  = '{8'h7F, 8'h01, 4'd0,  8'h80, 0, 0, 1, 1};
    tbl[2]  = '{8'h08, 8'h04, 4'd1,  8'h04, 0, 0, 0, 0};
    tbl[3]  = '{8'h00, 8'h01, 4'd1,  8'hFF, 1, 0, 0, 1};
    tbl[4]  = '{8'hCC, 8'hAA, 4'd2,  8'h88, 0, 0, 0, 1};
    tbl[5]  = '{8'hCC, 8'hAA, 4'd3,  8'hEE, 0, 0, 0, 1};
    tbl[6]  = '{8'h08, 8'h02, 4'd13, 8'h10, 0, 0, 0, 0};
    tbl[7]  = '{8'h20, 8'h10, 4'd13, 8'h00, 1, 1, 1, 0};
    tbl[8]  = '{8'h08, 8'h02, 4'd14, 8'h04, 0, 0, 0, 0};
    tbl[9]  = '{8'h08, 8'h00, 4'd14, 8'hFF, 1, 0, 0, 1};
    tbl[10] = '{8'h81, 8'h00, 4'd9,  8'h02, 1, 0, 0, 0};
    tbl[11] = '{8'h01, 8'h00, 4'd12, 8'h80, 1, 0, 0, 1};
    tbl[12] = '{8'h80, 8'h00, 4'd15, 8'hC0, 0, 0, 0, 1};
    tbl[13] = '{8'h80, 8'h00, 4'd11, 8'h01, 1, 0, 0, 0};
    tbl[14] = '{8'h00, 8'h00, 4'd5,  8'hFF, 0, 0, 0, 1};
    tbl[15] = '{8'hFF, 8'hFF, 4'd4,  8'h00, 0, 1, 0, 0};

    // Reset held while clocking: outputs stay cleared.
    rst_n = 1'b0;
    drive(8'hFF, 8'h01, 4'd0);
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", 12'h000);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("first_after_reset", {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].op);
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i),
             {tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].v, tbl[i].s});
    end

    // Back-to-back: new inputs must not show before the edge, and must after it.
    prev = {tbl[15].res, tbl[15].c, tbl[15].z, tbl[15].v, tbl[15].s};
    for (int i = 0; i < 6; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 4'(i * 3);
      drive(ra, rb, rop);
      #1 chk($sformatf("b2b_hold%0d", i), prev);
      exp = model(ra, rb, rop);
      @(posedge clk);
      #1 chk($sformatf("b2b_new%0d", i), exp);
      prev = exp;
    end

    // Random sweep, including forced zero-divisor and edge operands.
    for (int i = 0; i < 400; i++) begin
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 8'h80;
      rop = 4'($urandom_range(0, 15));
      drive(ra, rb, rop);
      @(posedge clk);
      #1 chk($sformatf("rand%0d op=%0d a=%h b=%h", i, rop, ra, rb), model(ra, rb, rop));
    end

    // Mid-stream asynchronous reset: clears without a clock edge.
    drive(8'h7F, 8'h01, 4'd0);
    @(posedge clk);
    #1 chk("pre_async_reset", model(8'h7F, 8'h01, 4'd0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 12'h000);
    #5 rst_n = 1'b1;
    drive(8'h20, 8'h10, 4'd13);
    @(posedge clk);
    #1 chk("after_async_reset", model(8'h20, 8'h10, 4'd13));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit registered ALU with 16 opcodes: add/sub, bitwise logic, shift/rotate, unsigned multiply, unsigned divide.
- Produces result plus carry, zero, overflow and sign flags.
- Sits in the datapath between the operand sources and the writeback/flag register consumers.
- Operands and opcode are sampled on each rising clock edge; result and flags are registered, so latency is 1 cycle.

Parameters:
- None. Width is fixed at 8; opcode is fixed at 4 bits.

Ports:
- clk  input  1  system clock; rising edge active
- rst_n  input  1  asynchronous active-low reset
- A  input  8  operand A (unsigned, or two's complement for overflow)
- B  input  8  operand B
- opcode  input  4  operation select
- result  output  8  registered result
- carry  output  1  registered carry/borrow/error flag
- zero  output  1  registered; 1 when result == 8'h00
- overflow  output  1  registered signed-overflow flag
- sign  output  1  registered; equals result[7]

Behaviour:
- Reset: rst_n low immediately clears result, carry, zero, overflow and sign to 0. Outputs hold these values until the first rising edge after rst_n deasserts.
- Datapath: each rising edge registers the combinational function of the current A, B and opcode. No enable, no handshake; a new operation can start every cycle.
- Flags common to all opcodes: zero = (next_result == 0); sign = next_result[7].
- Per opcode (carry and overflow are 0 unless stated):
- 0000 ADD: result = (A+B)[7:0]; carry = bit 8 of the 9-bit sum; overflow = (A[7]==B[7]) && (result[7]!=A[7]).
- 0001 SUB: result = (A-B)[7:0]; carry = borrow, i.e. 1 when A<B unsigned; overflow = (A[7]!=B[7]) && (result[7]!=A[7]).
- 0010 AND: A & B.
- 0011 OR: A | B.
- 0100 XOR: A ^ B.
- 0101 NOT: ~A.
- 0110 NAND: ~(A & B).
- 0111 NOR: ~(A | B).
- 1000 XNOR: ~(A ^ B).
- 1001 SHL: A<<1; carry = A[7].
- 1010 SHR (logical): A>>1; carry = A[0].
- 1011 ROL: {A[6:0],A[7]}; carry = A[7].
- 1100 ROR: {A[0],A[7:1]}; carry = A[0].
- 1101 MUL: unsigned 16-bit product P = A*B; result = P[7:0]; carry = overflow = (P[15:8] != 0).
- 1110 DIV: unsigned quotient floor(A/B); remainder discarded.
- DIV by zero (B==0): result = 8'hFF, carry = 1, overflow = 0, so zero = 0 and sign = 1.
- 1111 ASR: {A[7],A[7:1]}; carry = A[0].
- Combinational paths must be fully specified (no latches); any undefined input bits produce no X on outputs after reset.

Decomposition:
- Shared package alu_8bit_pkg:
  - opcode localparams OP_ADD…OP_ASR with the encodings above;
  - DATA_W = 8.
- One natural sub-module: alu_8bit_divider, a combinational 8-bit unsigned restoring divider.
  - Outputs: quotient and a div_by_zero flag.
  - Instantiated once in alu_8bit.
- All other operations are inline in alu_8bit.

Test Plan:
- Hold rst_n=0 with A=8'hFF, B=8'h01, opcode=ADD, toggling clk -> all outputs stay 0. Release rst_n, then one edge -> result=00, carry=1, zero=1.
- ADD: A=0F, B=01 -> after 1 edge result=10, flags C0 Z0 V0 S0. ADD: A=7F, B=01 -> result=80, C0 Z0 V1 S1.
- SUB: A=08, B=04 -> result=04, all flags 0. SUB: A=00, B=01 -> result=FF, C1 Z0 V0 S1.
- AND: A=CC, B=AA -> result=88, S1, others 0. OR on the same operands -> result=EE, S1, others 0.
- MUL: A=08, B=02 -> result=10, all flags 0. MUL: A=20, B=10 -> result=00, C1 Z1 V1 S0.
- DIV: A=08, B=02 -> result=04, all flags 0. DIV: A=08, B=00 -> result=FF, C1 Z0 V0 S1.
- Back-to-back ops on consecutive cycles -> each result appears exactly 1 cycle later.
- Asserting rst_n mid-stream clears the outputs without waiting for a clock edge.
